regfile_writeback: RTL and testbench
====================================

# regfile_writeback

Write-back stage that owns the register file's write port (`rd`, `rd_data`, `reg_write`). It merges single-cycle ALU results with out-of-order-issued, in-order-returning load responses and formats load data per RV32I (LB/LH/LW/LBU/LHU). It tracks pending load destinations in a busy mask that decode uses for RAW stalls. It sits between execute/memory and the register file and registers every write by one cycle.

## Interface
Parameters:
- `LQ_DEPTH`, default 2: number of outstanding loads. Must be a power of two and ≥ 2.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `alu_valid` input 1: ALU result present this cycle; always accepted.
- `alu_rd` input 5: ALU destination register.
- `alu_data` input 32: ALU result.
- `ld_req_valid` input 1: load issue request.
- `ld_req_ready` output 1: load queue can accept; equals count < `LQ_DEPTH`.
- `ld_req_rd` input 5: load destination register.
- `ld_req_funct3` input 3: load type.
- `ld_req_addr_lo` input 2: byte address bits [1:0].
- `ld_resp_valid` input 1: memory returns a word.
- `ld_resp_ready` output 1: response accepted; equals queue non-empty && !hold_valid.
- `ld_resp_word` input 32: aligned 32-bit memory word.
- `rd` output 5: register file write address.
- `rd_data` output 32: register file write data.
- `reg_write` output 1: register file write enable.
- `busy_mask` output 32: bit r=1 means register r has an uncommitted pending load write.
- `wb_stall` output 1: equals hold_valid; upstream must not present `alu_valid` in the next cycle.

## Operation
- Load queue: circular FIFO holding {rd, funct3, addr_lo}.
  - Push on `ld_req_valid && ld_req_ready`.
  - Pop on `ld_resp_valid && ld_resp_ready`.
  - Push and pop in the same cycle are both allowed; count is unchanged.
  - Pointers wrap modulo `LQ_DEPTH`.
- `ld_resp_valid` while the queue is empty or the hold buffer is occupied: the response is not accepted and has no effect on state.
- Load formatting uses the popped entry:
  - funct3=000 LB: byte `addr_lo`, sign-extended.
  - 100 LBU: byte `addr_lo`, zero-extended.
  - 001 LH: halfword `addr_lo[1]`, sign-extended.
  - 101 LHU: halfword `addr_lo[1]`, zero-extended.
  - 010 and all other codes: the full word.
  - `addr_lo[0]` is ignored for halfwords.
- Hold buffer: one entry {rd, data}. A formatted load result goes here when `alu_valid` is high in the same cycle.
- Write arbitration each cycle, in priority order:
  1. `alu_valid`: ALU result.
  2. Hold buffer: the hold entry, then clear hold.
  3. Load accepted this cycle: the formatted load result.
  4. Otherwise: no write.
- If case 2 applies and a load response is accepted in the same cycle: impossible, because `ld_resp_ready` is low while hold is occupied.
- If the ALU wins and a load is accepted in the same cycle, the load goes to hold.
- Hold already full while `alu_valid` stays high (protocol violation of `wb_stall`): the ALU still wins, hold persists, no data is lost.
- Output register: `rd`, `rd_data`, `reg_write` load the selected write. `reg_write` is forced to 0 when the selected rd = 0, while `rd` and `rd_data` still update.
- `busy_mask` is combinational from state. Bit r (r≠0) is set if r matches any valid queue entry, the valid hold entry, or (`reg_write` && `rd`==r). Bit 0 is always 0.
- Duplicate rd in the queue is legal; the bit stays set until the last of those writes commits.

## Timing
- Reset (`rst` low, asynchronous): queue empty, pointers 0, hold invalid, `rd`=0, `rd_data`=0, `reg_write`=0, `busy_mask`=0, `ld_req_ready`=1, `ld_resp_ready`=0, `wb_stall`=0.
  - Reset mid-operation discards all pending loads.
- ALU latency: `alu_valid` in cycle t gives `reg_write`=1 in cycle t+1. The register file captures the write at the end of t+1.
- Load latency:
  - Response accepted in t with no ALU conflict: write in t+1.
  - Conflict: write in the first cycle after t without `alu_valid`, plus 1.
- `busy_mask` bit rises in the cycle after issue. It falls in the cycle after the `reg_write` cycle for that load.
- `ld_req_ready` and `ld_resp_ready` depend only on state, never on same-cycle inputs.

## Test plan
- Reset, then `alu_valid`, rd=5, data=0x1234 → cycle+1: `reg_write`=1, `rd`=5, `rd_data`=0x00001234; next cycle `reg_write`=0.
- Issue LB rd=3, addr_lo=2; respond word 0x12805634 → write rd=3, data=0xFFFFFF80. Repeat as LBU → data=0x00000080; LH addr_lo=2 → 0x00001280; LHU addr_lo=0 with word 0x0000F00D → 0x0000F00D.
- Load response in the same cycle as `alu_valid` rd=7 → ALU written first, `wb_stall`=1 and `ld_resp_ready`=0 for one cycle, load written the next cycle.
- Issue 2 loads (rd=4, rd=4) → `ld_req_ready`=0; `busy_mask` bit 4 stays set until the second load's `reg_write` cycle has passed.
- ALU or load with rd=0 → `reg_write`=0 and `busy_mask`=0 throughout.
- Assert `rst` low asynchronously with 2 loads pending → outputs zero immediately; a stale `ld_resp_valid` after release causes no write.

Source files
------------

// File: rtl/regfile_writeback.sv
// Write-back stage: merges ALU results with in-order load responses, formats RV32I
// load data, and drives the register file write port one cycle later.
module regfile_writeback #(
  parameter int LQ_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        ld_req_valid,
  output logic        ld_req_ready,
  input  logic [4:0]  ld_req_rd,
  input  logic [2:0]  ld_req_funct3,
  input  logic [1:0]  ld_req_addr_lo,
  input  logic        ld_resp_valid,
  output logic        ld_resp_ready,
  input  logic [31:0] ld_resp_word,
  output logic [4:0]  rd,
  output logic [31:0] rd_data,
  output logic        reg_write,
  output logic [31:0] busy_mask,
  output logic        wb_stall
);

  localparam int PTR_W = $clog2(LQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [4:0]       q_rd [LQ_DEPTH];
  logic [2:0]       q_f3 [LQ_DEPTH];
  logic [1:0]       q_lo [LQ_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;

  logic        hold_valid;
  logic [4:0]  hold_rd;
  logic [31:0] hold_data;

  logic        push, pop;
  logic [4:0]  head_rd;
  logic [2:0]  head_f3;
  logic [1:0]  head_lo;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_fmt;

  logic        sel_valid;
  logic [4:0]  sel_rd;
  logic [31:0] sel_data;

  assign ld_req_ready  = count < CNT_W'(LQ_DEPTH);
  assign ld_resp_ready = (count != '0) && !hold_valid;
  assign wb_stall      = hold_valid;
  assign push          = ld_req_valid && ld_req_ready;
  assign pop           = ld_resp_valid && ld_resp_ready;

  assign head_rd = q_rd[rd_ptr];
  assign head_f3 = q_f3[rd_ptr];
  assign head_lo = q_lo[rd_ptr];

  // Queue payload needs no reset; validity comes from the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      q_rd[wr_ptr] <= ld_req_rd;
      q_f3[wr_ptr] <= ld_req_funct3;
      q_lo[wr_ptr] <= ld_req_addr_lo;
    end
  end

  always_comb begin
    ld_byte = ld_resp_word[7:0];
    case (head_lo)
      2'd1:    ld_byte = ld_resp_word[15:8];
      2'd2:    ld_byte = ld_resp_word[23:16];
      2'd3:    ld_byte = ld_resp_word[31:24];
      default: ld_byte = ld_resp_word[7:0];
    endcase
    ld_half = head_lo[1] ? ld_resp_word[31:16] : ld_resp_word[15:0];
    case (head_f3)
      3'b000:  ld_fmt = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_fmt = {24'd0, ld_byte};
      3'b001:  ld_fmt = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_fmt = {16'd0, ld_half};
      default: ld_fmt = ld_resp_word;
    endcase
  end

  // ALU always wins; a held load drains before a freshly accepted one.
  always_comb begin
    sel_valid = 1'b0;
    sel_rd    = alu_rd;
    sel_data  = alu_data;
    if (alu_valid) begin
      sel_valid = 1'b1;
    end else if (hold_valid) begin
      sel_valid = 1'b1;
      sel_rd    = hold_rd;
      sel_data  = hold_data;
    end else if (pop) begin
      sel_valid = 1'b1;
      sel_rd    = head_rd;
      sel_data  = ld_fmt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      hold_valid <= 1'b0;
      hold_rd    <= '0;
      hold_data  <= '0;
      rd         <= '0;
      rd_data    <= '0;
      reg_write  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (alu_valid) begin
        if (pop) begin
          hold_valid <= 1'b1;
          hold_rd    <= head_rd;
          hold_data  <= ld_fmt;
        end
      end else if (hold_valid) begin
        hold_valid <= 1'b0;
      end
      if (sel_valid) begin
        rd      <= sel_rd;
        rd_data <= sel_data;
      end
      reg_write <= sel_valid && (sel_rd != 5'd0);
    end
  end

  // A queue slot is live when its distance from the head is below count.
  always_comb begin
    logic [PTR_W-1:0] off;
    off       = '0;
    busy_mask = '0;
    for (int i = 0; i < LQ_DEPTH; i++) begin
      off = PTR_W'(i) - rd_ptr;
      if (CNT_W'(off) < count) busy_mask[q_rd[i]] = 1'b1;
    end
    if (hold_valid) busy_mask[hold_rd] = 1'b1;
    if (reg_write)  busy_mask[rd] = 1'b1;
    busy_mask[0] = 1'b0;
  end

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: directed scenarios then random traffic, all
// compared against a queue-based reference model of the write-back rules.
module tb_regfile_writeback;

  localparam int LQ_DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        ld_req_valid = 1'b0;
  logic        ld_req_ready;
  logic [4:0]  ld_req_rd = '0;
  logic [2:0]  ld_req_funct3 = '0;
  logic [1:0]  ld_req_addr_lo = '0;
  logic        ld_resp_valid = 1'b0;
  logic        ld_resp_ready;
  logic [31:0] ld_resp_word = '0;
  logic [4:0]  rd;
  logic [31:0] rd_data;
  logic        reg_write;
  logic [31:0] busy_mask;
  logic        wb_stall;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0] rd;
    logic [2:0] f3;
    logic [1:0] lo;
  } ld_t;

  ld_t         lq[$];
  bit          m_hold_v;
  logic [4:0]  m_hold_rd;
  logic [31:0] m_hold_data;
  bit          m_has_w;
  bit          exp_we;
  logic [4:0]  exp_rd;
  logic [31:0] exp_data;

  regfile_writeback #(.LQ_DEPTH(LQ_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_req_valid(ld_req_valid), .ld_req_ready(ld_req_ready),
    .ld_req_rd(ld_req_rd), .ld_req_funct3(ld_req_funct3), .ld_req_addr_lo(ld_req_addr_lo),
    .ld_resp_valid(ld_resp_valid), .ld_resp_ready(ld_resp_ready), .ld_resp_word(ld_resp_word),
    .rd(rd), .rd_data(rd_data), .reg_write(reg_write),
    .busy_mask(busy_mask), .wb_stall(wb_stall)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] fmt(input logic [2:0] f3, input logic [1:0] lo,
                                      input logic [31:0] word);
    logic [31:0] b, h;
    b = (word >> (8 * lo)) % 256;
    h = (word >> (16 * lo[1])) % 65536;
    case (f3)
      3'b000:  return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'b100:  return b;
      3'b001:  return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'b101:  return h;
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] model_busy();
    logic [31:0] m;
    m = '0;
    foreach (lq[i]) m[lq[i].rd] = 1'b1;
    if (m_hold_v) m[m_hold_rd] = 1'b1;
    if (exp_we) m[exp_rd] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

  task automatic model_reset();
    lq.delete();
    m_hold_v = 0; m_hold_rd = '0; m_hold_data = '0;
    m_has_w = 0; exp_we = 0; exp_rd = '0; exp_data = '0;
  endtask

  task automatic model_step();
    bit pop, push;
    ld_t e;
    logic [31:0] ld_d;
    logic [4:0] w_rd;
    logic [31:0] w_d;
    pop  = ld_resp_valid && lq.size() != 0 && !m_hold_v;
    push = ld_req_valid && lq.size() < LQ_DEPTH;
    ld_d = '0; w_rd = '0; w_d = '0;
    e = '{rd: 5'd0, f3: 3'd0, lo: 2'd0};
    if (pop) begin
      e = lq.pop_front();
      ld_d = fmt(e.f3, e.lo, ld_resp_word);
    end
    if (push) lq.push_back('{rd: ld_req_rd, f3: ld_req_funct3, lo: ld_req_addr_lo});
    m_has_w = 1;
    if (alu_valid) begin
      w_rd = alu_rd; w_d = alu_data;
      if (pop) begin m_hold_v = 1; m_hold_rd = e.rd; m_hold_data = ld_d; end
    end else if (m_hold_v) begin
      w_rd = m_hold_rd; w_d = m_hold_data; m_hold_v = 0;
    end else if (pop) begin
      w_rd = e.rd; w_d = ld_d;
    end else begin
      m_has_w = 0;
    end
    if (m_has_w) begin exp_rd = w_rd; exp_data = w_d; end
    exp_we = m_has_w && (w_rd != 5'd0);
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_state();
    check_output("ld_req_ready", 32'(ld_req_ready), 32'(lq.size() < LQ_DEPTH));
    check_output("ld_resp_ready", 32'(ld_resp_ready), 32'(lq.size() != 0 && !m_hold_v));
    check_output("wb_stall", 32'(wb_stall), 32'(m_hold_v));
    check_output("busy_mask", busy_mask, model_busy());
  endtask

  // Inputs are already set; check state-derived outputs, clock once, check the write.
  task automatic run_cycle();
    check_state();
    model_step();
    @(posedge clk);
    #1;
    check_output("reg_write", 32'(reg_write), 32'(exp_we));
    if (m_has_w) begin
      check_output("rd", 32'(rd), 32'(exp_rd));
      check_output("rd_data", rd_data, exp_data);
    end
  endtask

  task automatic clear_inputs();
    alu_valid = 0; ld_req_valid = 0; ld_resp_valid = 0;
  endtask

  task automatic apply_stimulus(input bit av, input logic [4:0] ar, input logic [31:0] ad,
                                input bit qv, input logic [4:0] qr, input logic [2:0] qf,
                                input logic [1:0] ql, input bit sv, input logic [31:0] sw);
    alu_valid = av; alu_rd = ar; alu_data = ad;
    ld_req_valid = qv; ld_req_rd = qr; ld_req_funct3 = qf; ld_req_addr_lo = ql;
    ld_resp_valid = sv; ld_resp_word = sw;
    run_cycle();
  endtask

  task automatic do_load(input logic [4:0] r, input logic [2:0] f3, input logic [1:0] lo,
                         input logic [31:0] word, input logic [31:0] expect_data);
    apply_stimulus(0, 0, 0, 1, r, f3, lo, 0, 0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 1, word);
    check_output("load_fmt_rd", 32'(rd), 32'(r));
    check_output("load_fmt_data", rd_data, expect_data);
    check_output("load_fmt_we", 32'(reg_write), 32'(r != 0));
  endtask

  initial begin
    model_reset();
    #2;
    check_output("reset_rd", 32'(rd), 32'd0);
    check_output("reset_rd_data", rd_data, 32'd0);
    check_output("reset_reg_write", 32'(reg_write), 32'd0);
    check_state();
    #10 rst = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] ALU write");
    apply_stimulus(1, 5'd5, 32'h1234, 0, 0, 0, 0, 0, 0);
    check_output("alu_rd", 32'(rd), 32'd5);
    check_output("alu_data", rd_data, 32'h0000_1234);
    check_output("alu_we", 32'(reg_write), 32'd1);
    clear_inputs();
    run_cycle();
    check_output("alu_we_drop", 32'(reg_write), 32'd0);

    $display("[TB] load formatting");
    do_load(5'd3, 3'b000, 2'd2, 32'h1280_5634, 32'hFFFF_FF80);
    do_load(5'd3, 3'b100, 2'd2, 32'h1280_5634, 32'h0000_0080);
    do_load(5'd3, 3'b001, 2'd2, 32'h1280_5634, 32'h0000_1280);
    do_load(5'd3, 3'b101, 2'd0, 32'h0000_F00D, 32'h0000_F00D);
    do_load(5'd6, 3'b001, 2'd1, 32'h0000_8001, 32'hFFFF_8001);
    do_load(5'd6, 3'b010, 2'd3, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

    $display("[TB] ALU/load conflict");
    apply_stimulus(0, 0, 0, 1, 5'd9, 3'b010, 2'd0, 0, 0);
    apply_stimulus(1, 5'd7, 32'hAAAA_5555, 0, 0, 0, 0, 1, 32'hCAFE_F00D);
    check_output("conflict_alu_rd", 32'(rd), 32'd7);
    check_output("conflict_stall", 32'(wb_stall), 32'd1);
    check_output("conflict_resp_ready", 32'(ld_resp_ready), 32'd0);
    clear_inputs();
    run_cycle();
    check_output("conflict_load_rd", 32'(rd), 32'd9);
    check_output("conflict_load_data", rd_data, 32'hCAFE_F00D);
    check_output("conflict_stall_clear", 32'(wb_stall), 32'd0);

    $display("[TB] duplicate destinations");
    apply_stimulus(0, 0, 0, 1, 5'd4, 3'b010, 2'd0, 0, 0);
    apply_stimulus(0, 0, 0, 1, 5'd4, 3'b010, 2'd0, 0, 0);
    check_output("full_req_ready", 32'(ld_req_ready), 32'd0);
    check_output("dup_busy4_a", 32'(busy_mask[4]), 32'd1);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'h1111_1111);
    check_output("dup_busy4_b", 32'(busy_mask[4]), 32'd1);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'h2222_2222);
    check_output("dup_busy4_c", 32'(busy_mask[4]), 32'd1);
    clear_inputs();
    run_cycle();
    check_output("dup_busy4_d", 32'(busy_mask[4]), 32'd0);

    $display("[TB] rd zero");
    apply_stimulus(1, 5'd0, 32'h5A5A_5A5A, 1, 5'd0, 3'b010, 2'd0, 0, 0);
    check_output("rd0_we_alu", 32'(reg_write), 32'd0);
    check_output("rd0_busy", busy_mask, 32'd0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'h7777_7777);
    check_output("rd0_we_load", 32'(reg_write), 32'd0);
    check_output("rd0_busy_load", busy_mask, 32'd0);

    $display("[TB] async reset with pending loads");
    apply_stimulus(0, 0, 0, 1, 5'd10, 3'b010, 2'd0, 0, 0);
    apply_stimulus(1, 5'd12, 32'h0BAD_F00D, 1, 5'd11, 3'b000, 2'd1, 0, 0);
    clear_inputs();
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_output("arst_rd", 32'(rd), 32'd0);
    check_output("arst_rd_data", rd_data, 32'd0);
    check_output("arst_reg_write", 32'(reg_write), 32'd0);
    check_state();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFF);
    check_output("stale_resp_we", 32'(reg_write), 32'd0);
    check_output("stale_resp_busy", busy_mask, 32'd0);

    $display("[TB] random traffic");
    for (int n = 0; n < 400; n++) begin
      bit av;
      av = ($urandom_range(0, 2) == 0) && (!m_hold_v || $urandom_range(0, 15) == 0);
      apply_stimulus(av, 5'($urandom_range(0, 7)), $urandom,
                     ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)),
                     3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                     ($urandom_range(0, 1) == 1), $urandom);
    end
    clear_inputs();
    for (int n = 0; n < 4; n++) run_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
